// File: rtl/fsm_arb_pkg.sv
// fsm_arb_pkg: shared state encoding and defaults for the run/done arbiters
package fsm_arb_pkg;
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RUN   = 3'd1,
      S_WAIT  = 3'd2,
      S_DONE  = 3'd3,
      S_ABORT = 3'd4
   } state_e;
   localparam int TIMEOUT_DEF = 16;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin selector, first set request above the pointer wins
module rr_pick #(
   parameter int N = 4,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic [N-1:0]  o_gnt,
   output logic [IW-1:0] o_idx,
   output logic          o_any
);
   logic [IW-1:0] cand;
   // scan from farthest to nearest so the closest hit above the pointer overwrites the rest
   always_comb begin
      o_gnt = '0;
      o_idx = '0;
      o_any = 1'b0;
      cand = '0;
      for (int i = N; i >= 1; i--) begin
         cand = IW'((int'(i_ptr) + i) % N);
         if (i_req[cand]) begin
            o_gnt = '0;
            o_gnt[cand] = 1'b1;
            o_idx = cand;
            o_any = 1'b1;
         end
      end
   end
endmodule

// File: rtl/fsm_run_arbiter.sv
// fsm_run_arbiter: round-robin sharing of one run/done engine with done timeout
module fsm_run_arbiter
   import fsm_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int TIMEOUT = TIMEOUT_DEF,
   localparam int ID_W = $clog2(NUM_REQ),
   localparam int CNT_W = $clog2(TIMEOUT + 1)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] i_req,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [ID_W-1:0]    o_grant_id,
   output logic [NUM_REQ-1:0] o_ack,
   output logic               o_run,
   input  logic               i_done,
   output logic               o_busy,
   output logic               o_timeout
);
   state_e state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [ID_W-1:0] ptr_q, ptr_d, id_q, id_d, pick_idx;
   logic [NUM_REQ-1:0] grant_q, grant_d, ack_q, ack_d, pick_gnt;
   logic run_q, run_d, tmo_q, tmo_d, pick_any;

   rr_pick #(.N(NUM_REQ)) u_pick (
      .i_req(i_req),
      .i_ptr(ptr_q),
      .o_gnt(pick_gnt),
      .o_idx(pick_idx),
      .o_any(pick_any)
   );

   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      ptr_d = ptr_q;
      grant_d = grant_q;
      id_d = id_q;
      ack_d = '0;
      run_d = 1'b0;
      tmo_d = 1'b0;
      case (state_q)
         S_IDLE: if (pick_any) begin
            state_d = S_RUN;
            grant_d = pick_gnt;
            id_d = pick_idx;
            run_d = 1'b1;
         end
         S_RUN: begin
            state_d = S_WAIT;
            cnt_d = '0;
         end
         S_WAIT: begin
            cnt_d = cnt_q + 1'b1;
            if (i_done) begin
               state_d = S_DONE;
               ack_d = grant_q;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               state_d = S_ABORT;
               tmo_d = 1'b1;
            end
         end
         S_DONE, S_ABORT: begin
            state_d = S_IDLE;
            ptr_d = id_q;
            grant_d = '0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q <= '0;
         ptr_q <= ID_W'(NUM_REQ - 1);
         grant_q <= '0;
         id_q <= '0;
         ack_q <= '0;
         run_q <= 1'b0;
         tmo_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         ptr_q <= ptr_d;
         grant_q <= grant_d;
         id_q <= id_d;
         ack_q <= ack_d;
         run_q <= run_d;
         tmo_q <= tmo_d;
      end
   end

   assign o_grant = grant_q;
   assign o_grant_id = id_q;
   assign o_ack = ack_q;
   assign o_run = run_q;
   assign o_timeout = tmo_q;
   assign o_busy = (state_q != S_IDLE);
endmodule

// File: tb/tb_fsm_run_arbiter.sv
// tb_fsm_run_arbiter: directed checks of grant order, done/ack timing, timeout and reset abandon
module tb_fsm_run_arbiter;
   localparam int TMO = 16;
   logic clk = 1'b0;
   logic reset;
   logic [3:0] i_req;
   logic i_done;
   logic [3:0] o_grant, o_ack;
   logic [1:0] o_grant_id;
   logic o_run, o_busy, o_timeout;
   int checks = 0;
   int errors = 0;

   fsm_run_arbiter #(.NUM_REQ(4), .TIMEOUT(TMO)) dut (
      .clk(clk),
      .reset(reset),
      .i_req(i_req),
      .o_grant(o_grant),
      .o_grant_id(o_grant_id),
      .o_ack(o_ack),
      .o_run(o_run),
      .i_done(i_done),
      .o_busy(o_busy),
      .o_timeout(o_timeout)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic outs(input string tag, input logic [3:0] g, input logic [1:0] id,
                       input logic [3:0] a, input logic r, input logic b, input logic t);
      chk({tag, ".grant"}, 32'(o_grant), 32'(g));
      chk({tag, ".ack"}, 32'(o_ack), 32'(a));
      chk({tag, ".run"}, 32'(o_run), 32'(r));
      chk({tag, ".busy"}, 32'(o_busy), 32'(b));
      chk({tag, ".timeout"}, 32'(o_timeout), 32'(t));
      if (b) chk({tag, ".id"}, 32'(o_grant_id), 32'(id));
   endtask

   // call in an IDLE cycle with requests already driven; dly=0 means the engine never answers
   task automatic job(input string tag, input logic [3:0] g, input logic [1:0] id, input int dly);
      step();
      outs({tag, ".run"}, g, id, 4'b0, 1'b1, 1'b1, 1'b0);
      if (dly > 0) begin
         repeat (dly) begin
            step();
            outs({tag, ".wait"}, g, id, 4'b0, 1'b0, 1'b1, 1'b0);
         end
         i_done = 1'b1;
         step();
         i_done = 1'b0;
         outs({tag, ".ack"}, g, id, g, 1'b0, 1'b1, 1'b0);
      end else begin
         repeat (TMO) begin
            step();
            outs({tag, ".wait"}, g, id, 4'b0, 1'b0, 1'b1, 1'b0);
         end
         step();
         outs({tag, ".abort"}, g, id, 4'b0, 1'b0, 1'b1, 1'b1);
      end
      step();
      outs({tag, ".idle"}, 4'b0, 2'd0, 4'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      reset = 1'b1;
      i_req = 4'b1111;
      i_done = 1'b0;
      repeat (3) begin
         step();
         outs("reset", 4'b0, 2'd0, 4'b0, 1'b0, 1'b0, 1'b0);
         chk("reset.id", 32'(o_grant_id), 32'd0);
      end
      reset = 1'b0;
      job("rr0", 4'b0001, 2'd0, 5);
      job("rr1", 4'b0010, 2'd1, 5);
      job("rr2", 4'b0100, 2'd2, 5);
      job("rr3", 4'b1000, 2'd3, 5);
      job("rr4", 4'b0001, 2'd0, 5);
      i_req = 4'b0001;
      job("single", 4'b0001, 2'd0, 5);
      i_req = 4'b1111;
      job("tmo", 4'b0010, 2'd1, 0);
      job("after_tmo", 4'b0100, 2'd2, 5);
      i_req = 4'b0000;
      i_done = 1'b1;
      step();
      outs("spur_idle", 4'b0, 2'd0, 4'b0, 1'b0, 1'b0, 1'b0);
      i_done = 1'b0;
      i_req = 4'b1000;
      step();
      outs("spur_run", 4'b1000, 2'd3, 4'b0, 1'b1, 1'b1, 1'b0);
      i_done = 1'b1;
      step();
      i_done = 1'b0;
      outs("spur_wait", 4'b1000, 2'd3, 4'b0, 1'b0, 1'b1, 1'b0);
      step();
      outs("spur_wait2", 4'b1000, 2'd3, 4'b0, 1'b0, 1'b1, 1'b0);
      i_done = 1'b1;
      step();
      i_req = 4'b0000;
      outs("spur_ack", 4'b1000, 2'd3, 4'b1000, 1'b0, 1'b1, 1'b0);
      step();
      outs("spur_done", 4'b0, 2'd0, 4'b0, 1'b0, 1'b0, 1'b0);
      step();
      i_done = 1'b0;
      outs("spur_idle2", 4'b0, 2'd0, 4'b0, 1'b0, 1'b0, 1'b0);
      i_req = 4'b0010;
      job("pre_rst", 4'b0010, 2'd1, 3);
      i_req = 4'b0100;
      step();
      outs("rst_run", 4'b0100, 2'd2, 4'b0, 1'b1, 1'b1, 1'b0);
      repeat (4) begin
         step();
         outs("rst_wait", 4'b0100, 2'd2, 4'b0, 1'b0, 1'b1, 1'b0);
      end
      reset = 1'b1;
      i_req = 4'b1111;
      step();
      outs("rst_mid", 4'b0, 2'd0, 4'b0, 1'b0, 1'b0, 1'b0);
      chk("rst_mid.id", 32'(o_grant_id), 32'd0);
      reset = 1'b0;
      job("post_rst", 4'b0001, 2'd0, 2);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
